edge_evt_arbiter: RTL and testbench
===================================

# edge_evt_arbiter

Collects edge events from N asynchronous 1-bit inputs (triggers, keys, sensor strobes) and serialises them onto one valid/ready event channel for a single downstream consumer. Each input is synchronised and edge-detected per channel; detected events are held as pending and granted round-robin. It sits between raw board inputs and the capture/control logic, so that logic never sees more than one event per cycle.

## Interface
Parameters:
- N, 4, number of input channels (2..16)
- SYNC_STAGES, 2, synchroniser flops per channel (≥2)
- EDGE_MODE, 2, 0 = rising only, 1 = falling only, 2 = both

Ports:
- clk  input  1  system clock, 50 MHz
- rst  input  1  asynchronous, active-high reset
- iData  input  N  raw asynchronous inputs
- iMask  input  N  1 = channel disabled (new edges ignored)
- iReady  input  1  consumer accepts the current event
- oValid  output  1  event available
- oId  output  max(1,$clog2(N))  channel index of the event
- oPol  output  1  1 = rising edge, 0 = falling edge
- iClrOvr  input  1  clears all oOverrun bits
- oOverrun  output  N  sticky: event dropped on that channel

## Operation
- Per channel: SYNC_STAGES-flop synchroniser, then a one-cycle delay; rise = sync & ~dly, fall = ~sync & dly; qualified by EDGE_MODE and ~iMask.
- Pending array: pend[i], pol[i]. Qualified edge with pend[i]=0 (or pend[i] being cleared this cycle by a load) sets pend[i]=1 and pol[i]=edge polarity.
- Edge with pend[i]=1 that is not being loaded this cycle: event dropped, pol[i] unchanged, oOverrun[i] set.
- Output register load condition: oValid=0 or (oValid & iReady). On load: if any pend set, pick first set index searching from ptr, ptr+1, … wrapping mod N; drive oId/oPol, oValid=1, clear that pend bit, ptr = granted+1 (wraps to 0 after N-1). If none pending, oValid=0.
- oValid=1 & iReady=0: oId/oPol/oValid held stable; pending keeps accumulating.
- A channel may re-pend while its previous event sits in the output register.
- Masking a channel with pend set does not cancel it; it is still granted.
- oOverrun: set has priority over iClrOvr in the same cycle.
- Reset (any time, including mid-handshake): sync/delay flops, pend, pol, ptr, output register cleared; oValid=0, oId=0, oPol=0, oOverrun=0. Delay flops load the post-reset synchronised level without generating an edge for the first SYNC_STAGES+1 cycles after reset release.

## Timing
- iData level change first sampled at clk edge k: edge visible at k+SYNC_STAGES-1, pend set at k+SYNC_STAGES, oValid=1 at k+SYNC_STAGES+1 (k+3 for default), provided output register free.
- Back-to-back throughput: one event per cycle while iReady=1.
- Grant fairness: a pending channel waits at most N-1 grants.
- All outputs registered; no combinational path iReady→oValid/oId.

## Structure
- Shared include file: EDGE_RISE/EDGE_FALL/EDGE_BOTH localparam constants; reused by any other edge-qualified block.
- Sub-module edge_sync_det (one per channel, generate loop): synchroniser + delay + rise/fall outputs, async active-high reset.
- Top: pending array, round-robin picker (double-width masked priority encode), output register, overrun logic.

## Test plan
- Single rise on ch2, iReady=1, EDGE_MODE=2: oValid high at k+3 for one cycle, oId=2, oPol=1.
- Simultaneous rises on ch0..3 at same cycle, iReady=1: events granted 0,1,2,3 on four consecutive cycles; then ch1 and ch0 again → grant order 0,1 (ptr wrapped).
- iReady=0 with ch1 event presented, second ch1 edge then third ch1 edge: output held (oId=1); second edge pends; third sets oOverrun[1]=1; after iReady, exactly two ch1 events delivered.
- EDGE_MODE=0, ch3 falls then rises: only one event, oPol=1; iMask[3]=1 during a rise → no event, no overrun.
- iClrOvr asserted same cycle as new overrun on ch0: oOverrun[0] stays 1; next cycle iClrOvr alone → 0.
- rst pulsed while oValid=1 and three pend bits set: all outputs 0 next edge; no spurious event for static-high inputs after release.

Source files
------------

// File: rtl/edge_evt_arbiter_pkg.sv
// Shared definitions for edge-qualified event blocks.
// Edge mode constants plus the per-channel edge qualifier.
package edge_evt_arbiter_pkg;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;

    function automatic logic edgeQual(
        input int   mode,
        input logic rise,
        input logic fall
    );
        logic q;
        q = 1'b0;
        unique case (mode)
            EDGE_RISE: q = rise;
            EDGE_FALL: q = fall;
            EDGE_BOTH: q = rise | fall;
            default:   q = 1'b0;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/edge_sync_det.sv
// Per-channel synchroniser, delay flop and rise/fall detector.
// Edges are suppressed until the chain has settled after reset.
module edge_sync_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic iData,
    output logic oRise,
    output logic oFall
);

    localparam int WARM = SYNC_STAGES + 1;
    localparam int WW   = $clog2(WARM + 1);

    logic [SYNC_STAGES-1:0] syncQ;
    logic                   dly;
    logic [WW-1:0]          warmCnt;
    logic                   armed;
    logic                   lvl;

    assign lvl   = syncQ[SYNC_STAGES-1];
    assign armed = (warmCnt == WW'(WARM));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syncQ   <= '0;
            dly     <= 1'b0;
            warmCnt <= '0;
        end else begin
            syncQ <= {syncQ[SYNC_STAGES-2:0], iData};
            dly   <= lvl;
            if (!armed) begin
                warmCnt <= warmCnt + WW'(1);
            end
        end
    end

    // Delay flop tracks the level silently until armed
    assign oRise = armed & lvl & ~dly;
    assign oFall = armed & ~lvl & dly;

endmodule

// File: rtl/edge_evt_arbiter.sv
// Serialises synchronised edge events from N inputs onto one
// valid/ready channel with round-robin grant and sticky overrun.
module edge_evt_arbiter
    import edge_evt_arbiter_pkg::*;
#(
    parameter  int N           = 4,
    parameter  int SYNC_STAGES = 2,
    parameter  int EDGE_MODE   = EDGE_BOTH,
    localparam int IDW         = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   iData,
    input  logic [N-1:0]   iMask,
    input  logic           iReady,
    output logic           oValid,
    output logic [IDW-1:0] oId,
    output logic           oPol,
    input  logic           iClrOvr,
    output logic [N-1:0]   oOverrun
);

    logic [N-1:0]   rise;
    logic [N-1:0]   fall;
    logic [N-1:0]   qual;
    logic [N-1:0]   pend;
    logic [N-1:0]   pol;
    logic [N-1:0]   pendNxt;
    logic [N-1:0]   polNxt;
    logic [N-1:0]   clr;
    logic [N-1:0]   drop;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptrNxt;
    logic [IDW-1:0] grantId;
    logic           anyPend;
    logic           load;
    logic           take;

    for (genvar g = 0; g < N; g++) begin : gCh
        edge_sync_det #(
            .SYNC_STAGES(SYNC_STAGES)
        ) uDet (
            .clk  (clk),
            .rst  (rst),
            .iData(iData[g]),
            .oRise(rise[g]),
            .oFall(fall[g])
        );
        assign qual[g] = ~iMask[g] & edgeQual(EDGE_MODE, rise[g], fall[g]);
    end

    assign anyPend = |pend;
    assign load    = ~oValid | iReady;
    assign take    = load & anyPend;

    // Lowest set bit at or above ptr in the doubled vector wins
    always_comb begin
        logic [2*N-1:0] dbl;
        dbl     = {pend, pend};
        grantId = '0;
        for (int j = 2*N-1; j >= 0; j--) begin
            if (dbl[j] && (j >= int'(ptr)) && (j < int'(ptr) + N)) begin
                grantId = IDW'(j % N);
            end
        end
    end

    assign ptrNxt = (grantId == IDW'(N-1)) ? '0 : grantId + IDW'(1);

    always_comb begin
        clr     = '0;
        drop    = '0;
        pendNxt = pend;
        polNxt  = pol;
        for (int i = 0; i < N; i++) begin
            clr[i] = take && (grantId == IDW'(i));
            if (clr[i]) begin
                pendNxt[i] = 1'b0;
            end
            if (qual[i]) begin
                if (!pend[i] || clr[i]) begin
                    pendNxt[i] = 1'b1;
                    polNxt[i]  = rise[i];
                end else begin
                    drop[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend     <= '0;
            pol      <= '0;
            ptr      <= '0;
            oValid   <= 1'b0;
            oId      <= '0;
            oPol     <= 1'b0;
            oOverrun <= '0;
        end else begin
            pend     <= pendNxt;
            pol      <= polNxt;
            // A fresh drop outranks a clear in the same cycle
            oOverrun <= (oOverrun & ~{N{iClrOvr}}) | drop;
            if (load) begin
                oValid <= anyPend;
                if (anyPend) begin
                    oId  <= grantId;
                    oPol <= pol[grantId];
                    ptr  <= ptrNxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_edge_evt_arbiter.sv
// Directed bench for edge_evt_arbiter: latency, round-robin,
// backpressure/overrun, rise-only masking and reset recovery.
`timescale 1ns/1ps
module tb_edge_evt_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] data, mask, dataR, maskR;
    logic         ready, readyR, clrOvr, clrOvrR;
    logic         valid, pol, validR, polR;
    logic [1:0]   id, idR;
    logic [N-1:0] ovr, ovrR;
    int           nTests = 0;
    int           nFail  = 0;
    int           cnt;
    logic         capPol;
    logic [1:0]   capId;

    always #10 clk = ~clk;

    edge_evt_arbiter #(.N(N), .SYNC_STAGES(2), .EDGE_MODE(2)) dut (
        .clk(clk), .rst(rst), .iData(data), .iMask(mask),
        .iReady(ready), .oValid(valid), .oId(id), .oPol(pol),
        .iClrOvr(clrOvr), .oOverrun(ovr)
    );

    edge_evt_arbiter #(.N(N), .SYNC_STAGES(2), .EDGE_MODE(0)) dutR (
        .clk(clk), .rst(rst), .iData(dataR), .iMask(maskR),
        .iReady(readyR), .oValid(validR), .oId(idR), .oPol(polR),
        .iClrOvr(clrOvrR), .oOverrun(ovrR)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        data = '0; mask = '0; dataR = '0; maskR = '0;
        ready = 1'b1; readyR = 1'b1; clrOvr = 1'b0; clrOvrR = 1'b0;
        tick(2);
        chk("rst valid", valid, 0);
        chk("rst id", id, 0);
        chk("rst pol", pol, 0);
        chk("rst ovr", ovr, 0);
        rst = 1'b0;
        tick(6);

        // Single rise on ch2: valid exactly 3 edges after first sample
        data[2] = 1'b1;
        tick(3);
        chk("t1 early", valid, 0);
        tick();
        chk("t1 valid", valid, 1);
        chk("t1 id", id, 2);
        chk("t1 pol", pol, 1);
        tick();
        chk("t1 one-shot", valid, 0);

        // Simultaneous rises from ptr=0, then ch0/ch1 falls after wrap
        rst = 1'b1; data = '0;
        tick(2);
        rst = 1'b0;
        tick(6);
        data = 4'hF;
        tick(4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2 valid%0d", i), valid, 1);
            chk($sformatf("t2 id%0d", i), id, i);
            tick();
        end
        chk("t2 drained", valid, 0);
        data = 4'hC;
        tick(4);
        chk("t2 wrap id0", id, 0);
        chk("t2 wrap pol0", pol, 0);
        tick();
        chk("t2 wrap id1", id, 1);
        chk("t2 wrap v1", valid, 1);
        tick();
        chk("t2 wrap end", valid, 0);

        // Backpressure on ch1: one held, one pending, one dropped
        ready = 1'b0;
        data[1] = 1'b1;
        tick(4);
        chk("t3 present", valid, 1);
        chk("t3 id", id, 1);
        data[1] = 1'b0;
        tick(2);
        data[1] = 1'b1;
        tick(5);
        chk("t3 held v", valid, 1);
        chk("t3 held id", id, 1);
        chk("t3 held pol", pol, 1);
        chk("t3 ovr", ovr, 4'b0010);
        ready = 1'b1;
        cnt = 0; capPol = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (valid) begin
                cnt++;
                if (cnt == 2) capPol = pol;
            end
            tick();
        end
        chk("t3 count", cnt, 2);
        chk("t3 2nd pol", capPol, 0);

        // Overrun set wins over a same-cycle clear
        clrOvr = 1'b1;
        tick();
        chk("t5 clr", ovr, 0);
        clrOvr = 1'b0;
        ready = 1'b0;
        data[0] = 1'b1;
        tick(4);
        chk("t5 present id", id, 0);
        data[0] = 1'b0;
        tick(3);
        data[0] = 1'b1;
        tick(2);
        clrOvr = 1'b1;
        tick();
        chk("t5 set beats clr", ovr, 4'b0001);
        tick();
        chk("t5 clr alone", ovr, 0);
        clrOvr = 1'b0;
        ready = 1'b1;
        tick(4);

        // Rise-only instance: falls ignored, masked rises ignored
        dataR[3] = 1'b1;
        tick(5);
        dataR[3] = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (validR) cnt++;
            tick();
        end
        chk("t4 fall ignored", cnt, 0);
        dataR[3] = 1'b1;
        cnt = 0; capId = '0; capPol = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (validR) begin
                cnt++;
                capId = idR;
                capPol = polR;
            end
            tick();
        end
        chk("t4 rise count", cnt, 1);
        chk("t4 rise id", capId, 3);
        chk("t4 rise pol", capPol, 1);
        maskR[3] = 1'b1;
        dataR[3] = 1'b0;
        tick(3);
        dataR[3] = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (validR) cnt++;
            tick();
        end
        chk("t4 masked count", cnt, 0);
        chk("t4 masked ovr", ovrR, 0);

        // Reset mid-handshake with three pending behind the output
        ready = 1'b0;
        data = '0;
        tick(5);
        chk("t6 pre valid", valid, 1);
        chk("t6 pre id", id, 1);
        rst = 1'b1;
        data = 4'hF;
        tick();
        chk("t6 rst valid", valid, 0);
        chk("t6 rst id", id, 0);
        chk("t6 rst pol", pol, 0);
        chk("t6 rst ovr", ovr, 0);
        rst = 1'b0;
        ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (valid) cnt++;
            tick();
        end
        chk("t6 no spurious", cnt, 0);
        data[3] = 1'b0;
        tick(4);
        chk("t6 after v", valid, 1);
        chk("t6 after id", id, 3);
        chk("t6 after pol", pol, 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
